// File: rtl/pr_stream_detector.sv
`default_nettype none
// ============================================================================
// Module   : pr_stream_detector
// Brief    : Multi-stream stride detector with throttled prefetch issue.
// Revision : 1.0 - initial release
// ============================================================================
module pr_stream_detector #(
    parameter int ADDR_BITS         = 16,
    parameter int BURST_LEN_WIDTH   = 8,
    parameter int TID_WIDTH         = 8,
    parameter int NUM_STREAMS       = 4,
    parameter int CONF_WIDTH        = 2,
    parameter int PRFETCH_FRQ_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           en,
    input  logic                           obs_valid,
    input  logic [ADDR_BITS-1:0]           obs_addr,
    input  logic [BURST_LEN_WIDTH-1:0]     obs_len,
    input  logic [TID_WIDTH-1:0]           obs_id,
    input  logic                           wr_valid,
    input  logic [ADDR_BITS-1:0]           wr_addr,
    input  logic [ADDR_BITS-1:0]           bar,
    input  logic [ADDR_BITS-1:0]           limit,
    input  logic [CONF_WIDTH-1:0]          crs_confThresh,
    input  logic [PRFETCH_FRQ_WIDTH-1:0]   crs_prBandwidthThrottle,
    output logic                           pf_valid,
    input  logic                           pf_ready,
    output logic [ADDR_BITS-1:0]           pf_addr,
    output logic [BURST_LEN_WIDTH-1:0]     pf_len,
    output logic [TID_WIDTH-1:0]           pf_id,
    output logic [$clog2(NUM_STREAMS)-1:0] pf_stream
);

    localparam int c_IDX_W = $clog2(NUM_STREAMS);
    localparam int c_EXT_W = ADDR_BITS + 1;

    // Stream table
    logic                         r_valid     [NUM_STREAMS];
    logic [TID_WIDTH-1:0]         r_id        [NUM_STREAMS];
    logic [BURST_LEN_WIDTH-1:0]   r_len       [NUM_STREAMS];
    logic [ADDR_BITS-1:0]         r_last      [NUM_STREAMS];
    logic [ADDR_BITS-1:0]         r_stride    [NUM_STREAMS];
    logic [CONF_WIDTH-1:0]        r_conf      [NUM_STREAMS];
    logic                         r_pend      [NUM_STREAMS];
    logic [ADDR_BITS-1:0]         r_pend_addr [NUM_STREAMS];

    logic [c_IDX_W-1:0]           r_victim;
    logic [c_IDX_W-1:0]           r_arb_ptr;
    logic [PRFETCH_FRQ_WIDTH-1:0] r_throttle;
    logic                         r_pf_valid;
    logic [ADDR_BITS-1:0]         r_pf_addr;
    logic [BURST_LEN_WIDTH-1:0]   r_pf_len;
    logic [TID_WIDTH-1:0]         r_pf_id;
    logic [c_IDX_W-1:0]           r_pf_stream;

    logic                         w_obs_acc;
    logic                         w_hit;
    logic [c_IDX_W-1:0]           w_hit_idx;
    logic                         w_free;
    logic [c_IDX_W-1:0]           w_free_idx;
    logic [c_IDX_W-1:0]           w_tgt;
    logic                         w_replace;
    logic                         w_same_len;
    logic [ADDR_BITS-1:0]         w_delta;
    logic [CONF_WIDTH-1:0]        w_thr;
    logic [ADDR_BITS-1:0]         w_new_stride;
    logic [CONF_WIDTH-1:0]        w_new_conf;
    logic                         w_obs_wr_pend;
    logic                         w_new_pend;
    logic [ADDR_BITS-1:0]         w_new_pend_addr;
    logic [NUM_STREAMS-1:0]       w_snoop;
    logic [NUM_STREAMS-1:0]       w_cand;
    logic                         w_can_issue;
    logic                         w_sel_ok;
    logic [c_IDX_W-1:0]           w_sel_idx;
    logic                         w_sel;
    logic                         w_hs;

    assign w_obs_acc = en && obs_valid && (obs_addr >= bar) && (obs_addr < limit);
    assign w_thr     = (crs_confThresh == '0) ? CONF_WIDTH'(1) : crs_confThresh;

    // Lowest-index hit and lowest-index free slot
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_id[i] == obs_id)) begin
                w_hit     = 1'b1;
                w_hit_idx = c_IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_tgt      = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_victim);
    assign w_replace  = w_obs_acc && !w_hit && !w_free;
    assign w_same_len = w_hit && (r_len[w_hit_idx] == obs_len);
    assign w_delta    = obs_addr - r_last[w_tgt];

    // Allocation and cleanup always rewrite pending; a plain hit only does so when it arms.
    always_comb begin
        w_new_stride    = '0;
        w_new_conf      = '0;
        w_obs_wr_pend   = 1'b1;
        w_new_pend      = 1'b0;
        w_new_pend_addr = '0;
        if (w_same_len) begin
            w_obs_wr_pend   = 1'b0;
            w_new_pend_addr = r_pend_addr[w_tgt];
            if (w_delta == '0) begin
                w_new_stride = r_stride[w_tgt];
            end else if (w_delta == r_stride[w_tgt]) begin
                w_new_stride = r_stride[w_tgt];
                w_new_conf   = (&r_conf[w_tgt]) ? r_conf[w_tgt]
                                                : r_conf[w_tgt] + CONF_WIDTH'(1);
            end else begin
                w_new_stride = w_delta;
            end
            if ((w_new_conf >= w_thr) && (w_new_stride != '0)) begin
                w_obs_wr_pend   = 1'b1;
                w_new_pend_addr = obs_addr + w_new_stride;
                w_new_pend      = (w_new_pend_addr >= bar) && (w_new_pend_addr < limit);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_entry
        logic [c_EXT_W-1:0] w_snoop_hi;
        assign w_snoop_hi   = c_EXT_W'(r_pend_addr[gi]) + c_EXT_W'(r_len[gi]);
        assign w_snoop[gi]  = wr_valid && r_pend[gi] && (wr_addr >= r_pend_addr[gi]) &&
                              (c_EXT_W'(wr_addr) <= w_snoop_hi);
        // An entry being observed or snooped this cycle is not offered to the arbiter.
        assign w_cand[gi]   = r_pend[gi] && !w_snoop[gi] &&
                              !(w_obs_acc && (w_tgt == c_IDX_W'(gi)));
    end

    // Round-robin search starting just after the last issued entry
    always_comb begin
        w_sel_ok  = 1'b0;
        w_sel_idx = '0;
        for (int k = NUM_STREAMS; k >= 1; k--) begin
            if (w_cand[r_arb_ptr + c_IDX_W'(k)]) begin
                w_sel_ok  = 1'b1;
                w_sel_idx = r_arb_ptr + c_IDX_W'(k);
            end
        end
    end

    assign w_can_issue = en && !r_pf_valid && (r_throttle == '0);
    assign w_sel       = w_can_issue && w_sel_ok;
    assign w_hs        = r_pf_valid && pf_ready;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                r_valid[i]     <= 1'b0;
                r_id[i]        <= '0;
                r_len[i]       <= '0;
                r_last[i]      <= '0;
                r_stride[i]    <= '0;
                r_conf[i]      <= '0;
                r_pend[i]      <= 1'b0;
                r_pend_addr[i] <= '0;
            end
            r_victim    <= '0;
            r_arb_ptr   <= '0;
            r_throttle  <= '0;
            r_pf_valid  <= 1'b0;
            r_pf_addr   <= '0;
            r_pf_len    <= '0;
            r_pf_id     <= '0;
            r_pf_stream <= '0;
        end else begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (w_obs_acc && (w_tgt == c_IDX_W'(i))) begin
                    r_valid[i]  <= 1'b1;
                    r_id[i]     <= obs_id;
                    r_len[i]    <= obs_len;
                    r_last[i]   <= obs_addr;
                    r_stride[i] <= w_new_stride;
                    r_conf[i]   <= w_new_conf;
                    if (w_obs_wr_pend) begin
                        r_pend[i]      <= w_new_pend;
                        r_pend_addr[i] <= w_new_pend_addr;
                    end else if (w_snoop[i]) begin
                        r_pend[i] <= 1'b0;
                    end
                end else if (w_snoop[i] || (w_sel && (w_sel_idx == c_IDX_W'(i)))) begin
                    r_pend[i] <= 1'b0;
                end
            end

            if (w_replace) begin
                r_victim <= r_victim + c_IDX_W'(1);
            end

            if (w_sel) begin
                r_pf_valid  <= 1'b1;
                r_pf_addr   <= r_pend_addr[w_sel_idx];
                r_pf_len    <= r_len[w_sel_idx];
                r_pf_id     <= r_id[w_sel_idx];
                r_pf_stream <= w_sel_idx;
                r_arb_ptr   <= w_sel_idx;
            end else if (w_hs) begin
                r_pf_valid <= 1'b0;
            end

            if (w_hs) begin
                r_throttle <= crs_prBandwidthThrottle;
            end else if (r_throttle != '0) begin
                r_throttle <= r_throttle - PRFETCH_FRQ_WIDTH'(1);
            end
        end
    end

    assign pf_valid  = r_pf_valid;
    assign pf_addr   = r_pf_addr;
    assign pf_len    = r_pf_len;
    assign pf_id     = r_pf_id;
    assign pf_stream = r_pf_stream;

endmodule
`default_nettype wire
